// File: rtl/saes_pkg.sv
// Shared types, S-box tables and GF(2^8) helpers for the iterative AES functional unit.
package saes_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } saes_state_e;

  typedef struct packed {
    logic subw;
    logic decsm;
    logic decs;
    logic encsm;
    logic encs;
  } saes_op_t;

  function automatic bit saes_params_ok(int unsigned xlen, int unsigned n_sbox);
    if (xlen == 32) return (n_sbox == 1) || (n_sbox == 2) || (n_sbox == 4);
    if (xlen == 64) return (n_sbox == 1) || (n_sbox == 2) || (n_sbox == 4) || (n_sbox == 8);
    return 1'b0;
  endfunction

  // Shift-and-add multiply reduced modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] xtN(logic [7:0] b, logic [7:0] n);
    return gf_mul(b, n);
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] b, int unsigned n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(logic [7:0] a);
    logic [7:0] r;
    logic [7:0] base;
    r    = 8'h01;
    base = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gf_mul(r, base);
      base = gf_mul(base, base);
    end
    return r;
  endfunction

  function automatic logic [2047:0] gen_sbox_fwd();
    logic [2047:0] t;
    logic [7:0]    v;
    t = '0;
    for (int i = 0; i < 256; i++) begin
      v = gf_inv(8'(i));
      t[8*i +: 8] = v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    end
    return t;
  endfunction

  function automatic logic [2047:0] gen_sbox_inv(logic [2047:0] fwd);
    logic [2047:0] t;
    t = '0;
    for (int i = 0; i < 256; i++) begin
      t[8*int'(fwd[8*i +: 8]) +: 8] = 8'(i);
    end
    return t;
  endfunction

  localparam logic [2047:0] SboxFwd = gen_sbox_fwd();
  localparam logic [2047:0] SboxInv = gen_sbox_inv(SboxFwd);

endpackage

// File: rtl/saes_sbox.sv
// Combinational AES S-box with forward/inverse select.
module saes_sbox
  import saes_pkg::*;
(
  input  logic [7:0] in_i,
  input  logic       inv_i,
  output logic [7:0] out_o
);

  always_comb begin
    out_o = inv_i ? SboxInv[{in_i, 3'b000} +: 8] : SboxFwd[{in_i, 3'b000} +: 8];
  end

endmodule

// File: rtl/saes_iter_fu.sv
// Iterative AES functional unit: saes32 enc/dec (with optional mix) and SubWord, with
// N_SBOX shared S-boxes walked across the operand bytes one group per cycle.
module saes_iter_fu
  import saes_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned N_SBOX = 1
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            valid,
  input  logic            op_encs,
  input  logic            op_encsm,
  input  logic            op_decs,
  input  logic            op_decsm,
  input  logic            op_subw,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [1:0]      bs,
  output logic [XLEN-1:0] rd,
  output logic            ready
);

  localparam int unsigned NBytes = XLEN / 8;
  localparam int unsigned GSubw  = (NBytes + N_SBOX - 1) / N_SBOX;
  localparam int unsigned CntW   = $clog2(NBytes) + 1;
  localparam logic [CntW-1:0] LastSubw = CntW'(GSubw - 1);

  if (!saes_params_ok(XLEN, N_SBOX)) begin : gen_bad_params
    $error("saes_iter_fu: illegal XLEN/N_SBOX combination");
  end

  saes_state_e            state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [31:0]            rs1_q, rs1_d;
  logic [XLEN-1:0]        rs2_q, rs2_d;
  logic [XLEN-1:0]        acc_q, acc_d;
  logic [XLEN-1:0]        rd_q, rd_d;
  logic [1:0]             bs_q, bs_d;
  saes_op_t               op_q, op_d, op_in;
  logic                   ready_q, ready_d;
  logic [N_SBOX-1:0][7:0] sbox_in, sbox_out;
  logic                   sbox_inv;
  logic                   last_grp;
  logic [7:0]             s;
  logic [31:0]            mix, rot, word;
  logic [XLEN-1:0]        saes32_res;
  logic                   unused_rs1;

  assign op_in      = {op_subw, op_decsm, op_decs, op_encsm, op_encs};
  assign sbox_inv   = op_q.decs | op_q.decsm;
  assign last_grp   = op_q.subw ? (cnt_q == LastSubw) : (cnt_q == '0);
  assign unused_rs1 = ^rs1;

  for (genvar l = 0; l < N_SBOX; l++) begin : gen_sbox
    saes_sbox u_sbox (
      .in_i  (sbox_in[l]),
      .inv_i (sbox_inv),
      .out_o (sbox_out[l])
    );
  end

  // Byte j belongs to group j / N_SBOX and is served by lane j % N_SBOX.
  always_comb begin
    sbox_in = '0;
    if (op_q.subw) begin
      for (int unsigned j = 0; j < NBytes; j++) begin
        if (32'(cnt_q) == j / N_SBOX) sbox_in[j % N_SBOX] = rs2_q[8*j +: 8];
      end
    end else begin
      sbox_in[0] = rs2_q[8*bs_q +: 8];
    end
  end

  always_comb begin
    s = sbox_out[0];
    if (op_q.encsm) begin
      mix = {xtN(s, 8'd3), s, s, xtN(s, 8'd2)};
    end else if (op_q.decsm) begin
      mix = {xtN(s, 8'd11), xtN(s, 8'd13), xtN(s, 8'd9), xtN(s, 8'd14)};
    end else begin
      mix = {24'h0, s};
    end
    unique case (bs_q)
      2'd0:    rot = mix;
      2'd1:    rot = {mix[23:0], mix[31:24]};
      2'd2:    rot = {mix[15:0], mix[31:16]};
      default: rot = {mix[7:0], mix[31:8]};
    endcase
    word       = rot ^ rs1_q;
    saes32_res = XLEN'(signed'(word));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    bs_d    = bs_q;
    op_d    = op_q;
    acc_d   = acc_q;
    rd_d    = rd_q;
    ready_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (valid) begin
          rs1_d = rs1[31:0];
          rs2_d = rs2;
          bs_d  = bs;
          op_d  = op_in;
          cnt_d = '0;
          acc_d = '0;
          if ($countones(op_in) != 1) begin
            rd_d    = '0;
            ready_d = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (!valid) begin
          state_d = StIdle;
        end else begin
          if (op_q.subw) begin
            for (int unsigned j = 0; j < NBytes; j++) begin
              if (32'(cnt_q) == j / N_SBOX) acc_d[8*j +: 8] = sbox_out[j % N_SBOX];
            end
          end else begin
            acc_d[7:0] = sbox_out[0];
          end
          if (last_grp) begin
            rd_d    = op_q.subw ? acc_d : saes32_res;
            ready_d = 1'b1;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      bs_q    <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      rd_q    <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      bs_q    <= bs_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      rd_q    <= rd_d;
      ready_q <= ready_d;
    end
  end

  assign rd    = rd_q;
  assign ready = ready_q;

endmodule
